// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/DONE control; tc pulses for one cycle at zero.
// Define COUNTDOWN_TIMER_AUTO_RELOAD_EN to restart from the last loaded value after each tc.
module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             tc
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             w_val_zero;

    assign w_val_zero = (load_val == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
        end else if (load) begin
            // Load wins over en in every state, including the tc cycle.
            r_reload <= load_val;
            r_count  <= load_val;
            r_state  <= w_val_zero ? ST_DONE : ST_RUN;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                ST_RUN: begin
                    if (en) begin
                        // Saturate at zero so the count can never wrap to all-ones.
                        if (r_count <= ONE) begin
                            r_count <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_count <= r_count - ONE;
                        end
                    end
                end
                ST_DONE: begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                    r_count <= r_reload;
                    r_state <= (r_reload == '0) ? ST_DONE : ST_RUN;
`else
                    r_count <= '0;
                    r_state <= ST_IDLE;
`endif
                end
                default: begin
                    // Illegal encoding: park in IDLE holding the last accepted start value.
                    r_count <= r_reload;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign a    = r_count;
    assign busy = (r_state == ST_RUN);
    assign tc   = (r_state == ST_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: vector table plus multi-cycle timing sequences.
// Expected values follow the build; define COUNTDOWN_TIMER_AUTO_RELOAD_EN for both files together.
module tb_countdown_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic [W-1:0] a;
    logic         busy;
    logic         tc;

    countdown_timer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .a        (a),
        .busy     (busy),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         rst;
        logic         load;
        logic [W-1:0] val;
        logic         en;
        logic [W-1:0] xa;
        logic         xbusy;
        logic         xtc;
    } vec_t;

    vec_t           vecs[$];
    logic [W+1:0]   exp_q[$];
    int             total = 0;
    int             bad   = 0;

    function automatic void add(string n, logic r, logic l, logic [W-1:0] v, logic e,
                                logic [W-1:0] xa, logic xb, logic xt);
        vec_t t;
        t.name = n; t.rst = r; t.load = l; t.val = v; t.en = e;
        t.xa = xa; t.xbusy = xb; t.xtc = xt;
        vecs.push_back(t);
    endfunction

    task automatic drive(input logic r, input logic l, input logic [W-1:0] v, input logic e);
        @(negedge clk);
        rst = r; load = l; load_val = v; en = e;
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string n, input int idx);
        logic [W+1:0] exp;
        exp = exp_q.pop_front();
        total++;
        if ({a, busy, tc} !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got a=%0d busy=%0b tc=%0b, want a=%0d busy=%0b tc=%0b",
                     n, idx, a, busy, tc, exp[W+1:2], exp[1], exp[0]);
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, '0, 1'b0);
        step_edge();
    endtask

    initial begin
        int cycles;
        int tc_count;
        int both_high;
        logic seen_tc;

        rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0;

`ifndef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        add("reset",    1, 0, 0, 0,  0, 0, 0);
        add("ld3",      0, 1, 3, 1,  3, 1, 0);
        add("ld3_cnt",  0, 0, 0, 1,  2, 1, 0);
        add("ld3_cnt",  0, 0, 0, 1,  1, 1, 0);
        add("ld3_tc",   0, 0, 0, 1,  0, 0, 1);
        add("ld3_idle", 0, 0, 0, 1,  0, 0, 0);
        add("idle_en",  0, 0, 0, 1,  0, 0, 0);
        add("ld0_tc",   0, 1, 0, 1,  0, 0, 1);
        add("ld0_idle", 0, 0, 0, 1,  0, 0, 0);
        add("ld5",      0, 1, 5, 1,  5, 1, 0);
        add("tog_hold", 0, 0, 0, 0,  5, 1, 0);
        add("tog_dec",  0, 0, 0, 1,  4, 1, 0);
        add("tog_hold", 0, 0, 0, 0,  4, 1, 0);
        add("tog_dec",  0, 0, 0, 1,  3, 1, 0);
        add("tog_hold", 0, 0, 0, 0,  3, 1, 0);
        add("tog_dec",  0, 0, 0, 1,  2, 1, 0);
        add("tog_hold", 0, 0, 0, 0,  2, 1, 0);
        add("tog_dec",  0, 0, 0, 1,  1, 1, 0);
        add("tog_hold", 0, 0, 0, 0,  1, 1, 0);
        add("tog_tc",   0, 0, 0, 1,  0, 0, 1);
        add("tog_idle", 0, 0, 0, 0,  0, 0, 0);
        add("ld4",      0, 1, 4, 1,  4, 1, 0);
        add("ld4_cnt",  0, 0, 0, 1,  3, 1, 0);
        add("ld4_cnt",  0, 0, 0, 1,  2, 1, 0);
        add("reld6",    0, 1, 6, 1,  6, 1, 0);
        add("reld6_cnt",0, 0, 0, 1,  5, 1, 0);
        add("reld6_hld",0, 0, 0, 0,  5, 1, 0);
        add("reld6_cnt",0, 0, 0, 1,  4, 1, 0);
        add("reld6_cnt",0, 0, 0, 1,  3, 1, 0);
        add("reld6_cnt",0, 0, 0, 1,  2, 1, 0);
        add("reld6_cnt",0, 0, 0, 1,  1, 1, 0);
        add("reld6_tc", 0, 0, 0, 1,  0, 0, 1);
        add("ld_on_tc", 0, 1, 2, 1,  2, 1, 0);
        add("ld2_cnt",  0, 0, 0, 1,  1, 1, 0);
        add("ld2_tc",   0, 0, 0, 1,  0, 0, 1);
        add("ld2_idle", 0, 0, 0, 0,  0, 0, 0);
        add("ld7",      0, 1, 7, 1,  7, 1, 0);
        add("ld7_cnt",  0, 0, 0, 1,  6, 1, 0);
        add("ld7_cnt",  0, 0, 0, 1,  5, 1, 0);
        add("ld7_cnt",  0, 0, 0, 1,  4, 1, 0);
        add("rst_run",  1, 0, 0, 1,  0, 0, 0);
        add("post_rst", 0, 0, 0, 1,  0, 0, 0);
        add("post_rst", 0, 0, 0, 1,  0, 0, 0);
        add("ld1",      0, 1, 1, 0,  1, 1, 0);
        add("ld1_tc",   0, 0, 0, 1,  0, 0, 1);
        add("rst_done", 1, 1, 5, 1,  0, 0, 0);
        add("ld15",     0, 1, 15, 0, 15, 1, 0);
        add("ld15_cnt", 0, 0, 0, 1,  14, 1, 0);
        add("rst_ld",   1, 1, 9, 1,  0, 0, 0);
`else
        add("reset",    1, 0, 0, 0,  0, 0, 0);
        add("ld2",      0, 1, 2, 1,  2, 1, 0);
        add("ld2_cnt",  0, 0, 0, 1,  1, 1, 0);
        add("ld2_tc",   0, 0, 0, 1,  0, 0, 1);
        add("auto_rl",  0, 0, 0, 1,  2, 1, 0);
        add("auto_cnt", 0, 0, 0, 1,  1, 1, 0);
        add("auto_tc",  0, 0, 0, 1,  0, 0, 1);
        add("auto_en0", 0, 0, 0, 0,  2, 1, 0);
        add("auto_hld", 0, 0, 0, 0,  2, 1, 0);
        add("auto_cnt", 0, 0, 0, 1,  1, 1, 0);
        add("auto_tc",  0, 0, 0, 1,  0, 0, 1);
        add("ld0_tc",   0, 1, 0, 1,  0, 0, 1);
        add("zero_tc",  0, 0, 0, 1,  0, 0, 1);
        add("zero_tc",  0, 0, 0, 0,  0, 0, 1);
        add("rst_done", 1, 0, 0, 1,  0, 0, 0);
        add("post_rst", 0, 0, 0, 1,  0, 0, 0);
        add("ld3",      0, 1, 3, 1,  3, 1, 0);
        add("ld3_cnt",  0, 0, 0, 1,  2, 1, 0);
        add("rst_ld",   1, 1, 9, 1,  0, 0, 0);
        add("ld1",      0, 1, 1, 1,  1, 1, 0);
        add("ld1_tc",   0, 0, 0, 1,  0, 0, 1);
        add("ld_on_tc", 0, 1, 6, 1,  6, 1, 0);
        add("ld6_cnt",  0, 0, 0, 1,  5, 1, 0);
        add("rst_run",  1, 0, 0, 1,  0, 0, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].load, vecs[i].val, vecs[i].en);
            exp_q.push_back({vecs[i].xa, vecs[i].xbusy, vecs[i].xtc});
            step_edge();
            check(vecs[i].name, i);
        end

        // Toggled enable: five decrements at every other edge put tc ten edges after load.
        do_reset();
        drive(1'b0, 1'b1, 4'd5, 1'b1);
        step_edge();
        cycles  = 0;
        seen_tc = 1'b0;
        for (int k = 1; k <= 40 && !seen_tc; k++) begin
            drive(1'b0, 1'b0, '0, (k % 2) == 0);
            step_edge();
            cycles++;
            seen_tc = tc;
        end
        total++;
        if (!seen_tc || cycles != 10) begin
            bad++;
            $display("FAIL tc_latency: got seen=%0b cycles=%0d, want seen=1 cycles=10", seen_tc, cycles);
        end

        // Free-running enable after load 2: count tc pulses over twelve edges.
        do_reset();
        drive(1'b0, 1'b1, 4'd2, 1'b1);
        step_edge();
        tc_count  = 0;
        both_high = 0;
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            step_edge();
            if (tc) tc_count++;
            if (tc && busy) both_high++;
        end
        total++;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        if (tc_count != 4) begin
            bad++;
            $display("FAIL tc_periodic: got tc_count=%0d, want 4", tc_count);
        end
`else
        if (tc_count != 1) begin
            bad++;
            $display("FAIL tc_single: got tc_count=%0d, want 1", tc_count);
        end
`endif
        total++;
        if (both_high != 0) begin
            bad++;
            $display("FAIL busy_tc_excl: got overlap=%0d, want 0", both_high);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
